// File: rtl/clock_reconfig_ctrl_if.sv
// Request/status handshake and MMCM DRP port of clock_reconfig_ctrl.
// The slave modport is the controller; the master modport is its environment.
interface clock_reconfig_ctrl_if #(
    parameter int NUM_MODES = 5
);
    localparam int MODE_W = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1;

    logic              req_valid;
    logic [MODE_W-1:0] req_mode;
    logic              req_ready;
    logic              busy;
    logic              done;
    logic              error;
    logic [MODE_W-1:0] current_mode;

    logic [6:0]        drp_addr;
    logic [15:0]       drp_di;
    logic [15:0]       drp_do;
    logic              drp_en;
    logic              drp_we;
    logic              drp_rdy;
    logic              mmcm_rst;
    logic              mmcm_locked;

    modport master (
        output req_valid, req_mode, drp_do, drp_rdy, mmcm_locked,
        input  req_ready, busy, done, error, current_mode,
               drp_addr, drp_di, drp_en, drp_we, mmcm_rst
    );

    modport slave (
        input  req_valid, req_mode, drp_do, drp_rdy, mmcm_locked,
        output req_ready, busy, done, error, current_mode,
               drp_addr, drp_di, drp_en, drp_we, mmcm_rst
    );
endinterface

// File: rtl/clock_reconfig_ctrl.sv
// MMCM reconfiguration sequencer: holds the MMCM in reset, read-modify-writes a
// per-mode list of DRP registers, releases reset and waits (bounded) for lock.
module clock_reconfig_ctrl #(
    parameter int NUM_MODES    = 5,
    parameter int NUM_REGS     = 5,
    parameter logic [38:0] DRP_TABLE [NUM_MODES][NUM_REGS] = '{
        '{ {7'h08, 16'hF000, 16'h0041}, {7'h09, 16'hFC00, 16'h0000}, {7'h14, 16'hF000, 16'h0041},
           {7'h15, 16'hFC00, 16'h0000}, {7'h16, 16'hC000, 16'h1041} },
        '{ {7'h08, 16'hF000, 16'h0186}, {7'h09, 16'hFC00, 16'h0080}, {7'h14, 16'hF000, 16'h0145},
           {7'h15, 16'hFC00, 16'h0000}, {7'h16, 16'hC000, 16'h1041} },
        '{ {7'h08, 16'hF000, 16'h028A}, {7'h09, 16'hFC00, 16'h0000}, {7'h14, 16'hF000, 16'h0145},
           {7'h15, 16'hFC00, 16'h0000}, {7'h16, 16'hC000, 16'h1041} },
        '{ {7'h08, 16'hF000, 16'h0514}, {7'h09, 16'hFC00, 16'h0000}, {7'h14, 16'hF000, 16'h0145},
           {7'h15, 16'hFC00, 16'h0000}, {7'h16, 16'hC000, 16'h1041} },
        '{ {7'h08, 16'hF000, 16'h0A28}, {7'h09, 16'hFC00, 16'h0000}, {7'h14, 16'hF000, 16'h0145},
           {7'h15, 16'hFC00, 16'h0000}, {7'h16, 16'hC000, 16'h1041} }
    },
    parameter int LOCK_TIMEOUT = 65535,
    parameter int DEFAULT_MODE = 0
) (
    input logic                  clk,
    input logic                  reset,
    clock_reconfig_ctrl_if.slave bus
);
    localparam int MODE_W = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1;
    localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int CNT_W  = ($clog2(LOCK_TIMEOUT + 1) > 16) ? $clog2(LOCK_TIMEOUT + 1) : 16;

    typedef enum logic [2:0] {
        IDLE, ASSERT_RST, RD, RD_WAIT, WR, WR_WAIT, RELEASE, LOCK_WAIT
    } state_t;

    state_t            state;
    logic [MODE_W-1:0] mode_q;
    logic [MODE_W-1:0] current_mode;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  nxt_idx;
    logic [CNT_W-1:0]  cnt;
    logic [38:0]       entry;
    logic [6:0]        next_addr;
    logic              req_ready, busy, done, error;
    logic              drp_en, drp_we, mmcm_rst;
    logic [6:0]        drp_addr;
    logic [15:0]       drp_di;

    // nxt_idx saturates so the table lookup below never leaves the array.
    always_comb begin
        nxt_idx = idx;
        if (int'(idx) < NUM_REGS - 1) nxt_idx = idx + 1'b1;
    end

    assign entry     = DRP_TABLE[mode_q][idx];
    assign next_addr = DRP_TABLE[mode_q][nxt_idx][38:32];

    // NOTE: all state and registered outputs use non-blocking assignments so every
    // branch sees the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            mode_q       <= '0;
            current_mode <= MODE_W'(DEFAULT_MODE);
            idx          <= '0;
            cnt          <= '0;
            req_ready    <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            drp_en       <= 1'b0;
            drp_we       <= 1'b0;
            drp_addr     <= '0;
            drp_di       <= '0;
            mmcm_rst     <= 1'b0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            unique case (state)
                IDLE: if (bus.req_valid) begin
                    if (int'(bus.req_mode) >= NUM_MODES) begin
                        error <= 1'b1;
                    end else begin
                        mode_q    <= bus.req_mode;
                        idx       <= '0;
                        mmcm_rst  <= 1'b1;
                        busy      <= 1'b1;
                        req_ready <= 1'b0;
                        state     <= ASSERT_RST;
                    end
                end
                ASSERT_RST: begin
                    drp_en   <= 1'b1;
                    drp_we   <= 1'b0;
                    drp_addr <= entry[38:32];
                    state    <= RD;
                end
                RD: begin
                    drp_en <= 1'b0;
                    state  <= RD_WAIT;
                end
                RD_WAIT: if (bus.drp_rdy) begin
                    // Keep-mask bits come from the live register, the rest from the table.
                    drp_di <= (bus.drp_do & entry[31:16]) | (entry[15:0] & ~entry[31:16]);
                    drp_en <= 1'b1;
                    drp_we <= 1'b1;
                    state  <= WR;
                end
                WR: begin
                    drp_en <= 1'b0;
                    drp_we <= 1'b0;
                    state  <= WR_WAIT;
                end
                WR_WAIT: if (bus.drp_rdy) begin
                    if (int'(idx) < NUM_REGS - 1) begin
                        idx      <= nxt_idx;
                        drp_en   <= 1'b1;
                        drp_we   <= 1'b0;
                        drp_addr <= next_addr;
                        state    <= RD;
                    end else begin
                        state <= RELEASE;
                    end
                end
                RELEASE: begin
                    mmcm_rst <= 1'b0;
                    cnt      <= '0;
                    state    <= LOCK_WAIT;
                end
                LOCK_WAIT: begin
                    // The first two cycles may still show lock from the old configuration.
                    if (cnt >= CNT_W'(2) && bus.mmcm_locked) begin
                        done         <= 1'b1;
                        current_mode <= mode_q;
                        busy         <= 1'b0;
                        req_ready    <= 1'b1;
                        state        <= IDLE;
                    end else if (cnt >= CNT_W'(LOCK_TIMEOUT - 1)) begin
                        error     <= 1'b1;
                        busy      <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready    = req_ready;
    assign bus.busy         = busy;
    assign bus.done         = done;
    assign bus.error        = error;
    assign bus.current_mode = current_mode;
    assign bus.drp_addr     = drp_addr;
    assign bus.drp_di       = drp_di;
    assign bus.drp_en       = drp_en;
    assign bus.drp_we       = drp_we;
    assign bus.mmcm_rst     = mmcm_rst;
endmodule
